// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains one burst of burst_len words from an async FIFO read port
// into a small skid buffer and replays them in order on a valid/ready stream.
//   clk, rst_n        read-domain clock, asynchronous active-low reset
//   start, burst_len  burst request (sampled in IDLE) and its word count
//   busy, done, err   activity flag, completion pulse, sticky spurious-Dout_valid flag
//   fifo_rd_en        FIFO read request; fifo_empty/fifo_dout/fifo_dout_valid FIFO read side
//   m_valid/m_data/m_ready/m_last  output stream, m_last marks the final word
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 4,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             fifo_rd_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_dout_valid,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             m_last
);
    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len_q, issued, sent;
    logic             pend_q;
    logic [WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [AW+1:0]    credit;
    logic             accept, push, pop, is_last;

    assign accept  = (state == IDLE) && start;
    assign push    = fifo_dout_valid && pend_q;
    assign pop     = m_valid && m_ready;
    assign is_last = sent == len_q - LEN_W'(1);
    // A read in flight already owns a buffer slot; pops this cycle are not credited.
    assign credit  = (AW+2)'(count) + (AW+2)'(pend_q);
    assign fifo_rd_en = (state == FETCH) && !fifo_empty && (issued < len_q)
                        && (credit < (AW+2)'(BUF_DEPTH));
    assign m_valid = count != '0;
    assign m_data  = buf_q[rd_ptr];
    assign m_last  = m_valid && is_last;
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((burst_len == '0) ? DONE : FETCH) : IDLE;
            FETCH:   state_n = (issued == len_q) ? DRAIN : FETCH;
            DRAIN:   state_n = (pop && is_last) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            len_q  <= '0;
            issued <= '0;
            sent   <= '0;
            pend_q <= 1'b0;
            err    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            state  <= state_n;
            // FIFO returns data exactly one cycle after an accepted read.
            pend_q <= fifo_rd_en;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            err    <= accept ? 1'b0 : (err || (fifo_dout_valid && !pend_q));
            if (accept) begin
                len_q  <= burst_len;
                issued <= '0;
                sent   <= '0;
            end else begin
                if (fifo_rd_en) issued <= issued + LEN_W'(1);
                if (pop) sent <= sent + LEN_W'(1);
            end
            if (push) begin
                buf_q[wr_ptr] <= fifo_dout;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: bench for fifo_burst_reader with a 1-cycle-latency FIFO model and
// an in-order word scoreboard; all DUT ports are driven or observed.
module tb_fifo_burst_reader;
    localparam int WIDTH = 8, BUF_DEPTH = 4, LEN_W = 8;

    logic             clk = 1'b0, rst_n = 1'b1, start = 1'b0, m_ready = 1'b0;
    logic             hold_empty = 1'b0, spur = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy, done, err, fifo_rd_en, fifo_empty, fifo_dout_valid;
    logic             m_valid, m_last;
    logic [WIDTH-1:0] fifo_dout, m_data;

    logic [WIDTH-1:0] fmem [512];
    logic [8:0]       fw = '0, fr = '0;
    logic [WIDTH-1:0] exp_q [$];
    logic [31:0]      cyc = '0;
    int               n_cmp = 0, n_err = 0;
    int               rd_cnt = 0, hs_cnt = 0, done_cnt = 0, rd0 = 0, hs0 = 0, done0 = 0;
    int               rmode = 0, emode = 0;
    logic             prev_stall = 1'b0, prev_lhs = 1'b0, prev_last = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    fifo_burst_reader #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .err(err), .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_dout_valid(fifo_dout_valid),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // FIFO read port: data and Dout_valid one cycle after an accepted read.
    assign fifo_empty = hold_empty || (fw == fr);
    always @(posedge clk) begin
        fifo_dout_valid <= fifo_rd_en || spur;
        if (fifo_rd_en) begin
            fifo_dout <= fmem[fr];
            fr        <= fr + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream scoreboard: words in FIFO order, m_last on word len-1, done right after it.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_lhs   = 1'b0;
        end else begin
            logic [WIDTH-1:0] exp_d;
            int               idx;
            if (prev_lhs) chk("done_after_last", done, 1);
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (fifo_rd_en) begin
                rd_cnt++;
                chk("rd_en_while_empty", fifo_empty, 0);
            end
            if (done) done_cnt++;
            prev_lhs = 1'b0;
            if (m_valid && m_ready) begin
                idx   = hs_cnt - hs0;
                exp_d = (idx < exp_q.size()) ? exp_q[idx] : 'x;
                chk("data", m_data, exp_d);
                chk("last", m_last, idx == exp_q.size() - 1);
                prev_lhs = idx == exp_q.size() - 1;
                hs_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (rmode == 1) m_ready = 1'b1;
        else if (rmode == 2) m_ready = 1'($urandom_range(0, 1));
        hold_empty = (emode == 1) ? cyc[1] : (emode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    task automatic start_burst(input int len, input int base);
        logic [WIDTH-1:0] d;
        fw = fr;
        exp_q.delete();
        for (int i = 0; i < len + 2; i++) begin
            d = (base != 0) ? WIDTH'(base + i) : WIDTH'($urandom);
            fmem[fw] = d;
            fw = fw + 1'b1;
            if (i < len) exp_q.push_back(d);
        end
        rd0 = rd_cnt;
        hs0 = hs_cnt;
        done0 = done_cnt;
        burst_len = LEN_W'(len);
        start = 1'b1;
        cycle();
        start = 1'b0;
        burst_len = LEN_W'($urandom);
    endtask

    task automatic wait_done(input int len, input bit lat, input bit poke);
        chk("busy_in_burst", busy, 1);
        chk("err_cleared", err, 0);
        for (int i = 0; i < 3000 && done_cnt == done0; i++) begin
            if (lat && i == 0) chk("lat_rd_en_c1", fifo_rd_en, 1);
            if (lat && i == 1) chk("lat_valid_c2", m_valid, 0);
            if (lat && i == 2) chk("lat_valid_c3", m_valid, 1);
            if (poke && i == 2) begin
                start = 1'b1;
                burst_len = 8'd7;
            end else if (poke && i == 3) start = 1'b0;
            cycle();
        end
        start = 1'b0;
        chk("done_count", done_cnt - done0, 1);
        chk("words", hs_cnt - hs0, len);
        chk("reads", rd_cnt - rd0, len);
        chk("busy_after", busy, 0);
        chk("err_after", err, 0);
        emode = 0;
        cycle();
        cycle();
        chk("done_once", done_cnt - done0, 1);
        chk("idle_valid", m_valid, 0);
    endtask

    task automatic run_burst(input int len, input int base, input bit lat, input bit poke);
        start_burst(len, base);
        wait_done(len, lat, poke);
    endtask

    initial begin
        // Reset with random inputs and a non-empty FIFO.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fmem[fw] = WIDTH'($urandom);
            fw = fw + 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom);
            burst_len = LEN_W'($urandom);
            m_ready = 1'($urandom);
            spur = 1'($urandom);
            cycle();
            chk("rst_outputs", {busy, done, err, fifo_rd_en, m_valid, m_last}, 0);
            chk("rst_data", m_data, 0);
        end
        start = 1'b0;
        spur = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("idle_outputs", {busy, done, err, fifo_rd_en, m_valid, m_last}, 0);

        // len=5 of 0x11..0x15 with m_ready held high, including first-word latency.
        rmode = 1;
        m_ready = 1'b1;
        run_burst(5, 'h11, 1'b1, 1'b0);

        // len=8 with downstream stalled: issue stops at the buffer depth.
        rmode = 0;
        m_ready = 1'b0;
        start_burst(8, 0);
        repeat (10) cycle();
        chk("stall_reads", rd_cnt - rd0, BUF_DEPTH);
        chk("stall_valid", m_valid, 1);
        chk("stall_head", m_data, exp_q[0]);
        rmode = 1;
        wait_done(8, 1'b0, 1'b0);

        // len=6 with the FIFO flagging empty every other pair of cycles.
        emode = 1;
        run_burst(6, 0, 1'b0, 1'b0);

        // Zero-length burst: straight to DONE, no reads.
        start_burst(0, 0);
        chk("zl_done", done, 1);
        chk("zl_rd_en", fifo_rd_en, 0);
        cycle();
        chk("zl_done_off", done, 0);
        chk("zl_busy", busy, 0);
        chk("zl_reads", rd_cnt - rd0, 0);
        chk("zl_done_count", done_cnt - done0, 1);

        // A start while busy is ignored.
        run_burst(5, 0, 1'b0, 1'b1);

        // Boundaries: single word and maximum length.
        run_burst(1, 0, 1'b0, 1'b0);
        run_burst(255, 0, 1'b0, 1'b0);

        // Random lengths, ready patterns and empty patterns.
        for (int k = 0; k < 10; k++) begin
            rmode = 2;
            emode = $urandom_range(0, 2);
            run_burst($urandom_range(1, 24), 0, 1'b0, 1'b0);
        end

        // Reset in the middle of an 8-word burst, then a clean 2-word burst.
        rmode = 1;
        start_burst(8, 0);
        for (int i = 0; i < 200 && (hs_cnt - hs0) < 3; i++) cycle();
        chk("reset_reached_word3", (hs_cnt - hs0) >= 3, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {busy, done, err, fifo_rd_en, m_valid, m_last}, 0);
        chk("midrst_data", m_data, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_done", done_cnt - done0, 0);
        run_burst(2, 0, 1'b0, 1'b0);

        // Spurious Dout_valid while idle sets err until the next start.
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        cycle();
        cycle();
        chk("spur_err", err, 1);
        chk("spur_dropped", m_valid, 0);
        repeat (3) cycle();
        chk("spur_err_sticky", err, 1);
        run_burst(3, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
